// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_pkg: shared types and constants for the two-port memory bus arbiter.
//   state_e     FSM encoding (IDLE, ACCESS, DONE)
//   PORT_CPU    index of requester port 0 (CPU core)
//   PORT_DMA    index of requester port 1 (DMA / video fetch)
//   DEF_ADDR_W  default address width
//   DEF_DATA_W  default data width
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: bundle of requester handshakes and the memory-side bus.
//   master modport: the arbiter (drives gnt/ack/rdata and the memory strobes)
//   slave modport : requesters plus memory model (drive req/we/addr/wdata, mem_rdata)
interface mem_bus_arbiter_if
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              req0;
   logic              we0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              gnt0;
   logic              ack0;

   logic              req1;
   logic              we1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              gnt1;
   logic              ack1;

   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_r;
   logic              mem_w;
   logic              busy;

   modport master (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  mem_rdata,
      output gnt0, ack0, gnt1, ack1,
      output rdata, mem_addr, mem_wdata, mem_r, mem_w, busy
   );

   modport slave (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output mem_rdata,
      input  gnt0, ack0, gnt1, ack1,
      input  rdata, mem_addr, mem_wdata, mem_r, mem_w, busy
   );

endinterface

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
//   req[1:0]   request per port
//   last       port that won the previous arbitration
//   grant[1:0] one-hot winner, 2'b00 when nothing is requested
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         // tie goes to whichever port did not win last time
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between port 0 (CPU) and port 1 (DMA),
// one byte transaction per grant, strobes held for WAIT_STATES+1 cycles.
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    requester handshakes, latched address/data, strobes, rdata, busy
//
// state  | meaning
// IDLE   | arbitrate; on a win latch request, pulse gnt, load wait timer
// ACCESS | mem_r/mem_w asserted, timer counts down to 0, read data captured at 0
// DONE   | strobes low, ack pulse for winner, winner becomes last_winner
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int WAIT_STATES = 1
) (
   input  logic clk,
   input  logic reset,
   mem_bus_arbiter_if.master bus
);

   if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
      $error("mem_bus_arbiter: WAIT_STATES must be 0..15");
   end

   state_e            state_q;
   state_e            state_d;
   logic [3:0]        wait_cnt_q;
   logic              winner_q;
   logic              last_winner_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        pick;
   logic              win;
   logic              grant_en;
   logic              wait_tc;

   rr_arb2 u_rr_arb2 (
      .req   ({bus.req1, bus.req0}),
      .last  (last_winner_q),
      .grant (pick)
   );

   assign wait_tc = (wait_cnt_q == 4'd0);

   always_comb begin
      state_d = state_q;
      win     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick != 2'b00) begin
               win     = 1'b1;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (wait_tc) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // gnt is a same-cycle decode of req, so it must also be masked while reset
   // is held or a pending request would show a grant during reset.
   assign grant_en = win & reset;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         wait_cnt_q    <= 4'd0;
         winner_q      <= PORT_CPU;
         last_winner_q <= PORT_DMA;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         rdata_q       <= '0;
      end else begin
         state_q <= state_d;
         if (win) begin
            winner_q   <= pick[1];
            we_q       <= pick[1] ? bus.we1    : bus.we0;
            addr_q     <= pick[1] ? bus.addr1  : bus.addr0;
            wdata_q    <= pick[1] ? bus.wdata1 : bus.wdata0;
            wait_cnt_q <= 4'(WAIT_STATES);
         end else if (state_q == ACCESS && !wait_tc) begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
         end
         if (state_q == ACCESS && wait_tc && !we_q) rdata_q <= bus.mem_rdata;
         if (state_q == DONE) last_winner_q <= winner_q;
      end
   end

   // Strobes and acks decode straight from the state register so an async
   // reset drops them without waiting for a clock edge.
   assign bus.gnt0      = grant_en & pick[0];
   assign bus.gnt1      = grant_en & pick[1];
   assign bus.ack0      = (state_q == DONE) && (winner_q == PORT_CPU);
   assign bus.ack1      = (state_q == DONE) && (winner_q == PORT_DMA);
   assign bus.mem_r     = (state_q == ACCESS) && !we_q;
   assign bus.mem_w     = (state_q == ACCESS) && we_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed bench for mem_bus_arbiter with WAIT_STATES of
// 1 (main instance), 0 and 3 (strobe-width / latency instances).
module tb_mem_bus_arbiter;
   logic clk;
   logic reset;
   int   n_chk;
   int   n_pass;
   int   n_fail;

   mem_bus_arbiter_if bus_m ();
   mem_bus_arbiter_if bus_a ();
   mem_bus_arbiter_if bus_b ();

   mem_bus_arbiter #(.WAIT_STATES(1)) dut (.clk(clk), .reset(reset), .bus(bus_m));
   mem_bus_arbiter #(.WAIT_STATES(0)) dut_ws0 (.clk(clk), .reset(reset), .bus(bus_a));
   mem_bus_arbiter #(.WAIT_STATES(3)) dut_ws3 (.clk(clk), .reset(reset), .bus(bus_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      n_chk = 0; n_pass = 0; n_fail = 0;
      reset = 1'b0;
      bus_m.req0 = 0; bus_m.we0 = 0; bus_m.addr0 = 0; bus_m.wdata0 = 0;
      bus_m.req1 = 0; bus_m.we1 = 0; bus_m.addr1 = 0; bus_m.wdata1 = 0;
      bus_m.mem_rdata = 0;
      bus_a.req0 = 0; bus_a.we0 = 0; bus_a.addr0 = 0; bus_a.wdata0 = 0;
      bus_a.req1 = 0; bus_a.we1 = 0; bus_a.addr1 = 0; bus_a.wdata1 = 0;
      bus_a.mem_rdata = 0;
      bus_b.req0 = 0; bus_b.we0 = 0; bus_b.addr0 = 0; bus_b.wdata0 = 0;
      bus_b.req1 = 0; bus_b.we1 = 0; bus_b.addr1 = 0; bus_b.wdata1 = 0;
      bus_b.mem_rdata = 0;

      // reset state
      repeat (2) @(posedge clk);
      #2;
      bus_m.req0 = 1;
      #1;
      chk("rst_gnt0", 32'(bus_m.gnt0), 0);
      chk("rst_busy", 32'(bus_m.busy), 0);
      chk("rst_mem_r", 32'(bus_m.mem_r), 0);
      chk("rst_mem_addr", 32'(bus_m.mem_addr), 0);
      chk("rst_rdata", 32'(bus_m.rdata), 0);
      bus_m.req0 = 0;
      step();
      reset = 1'b1;

      // contention: both held high, strict alternation starting with port 0
      bus_m.addr0 = 'h1000; bus_m.addr1 = 'h1001;
      bus_m.req0 = 1; bus_m.req1 = 1;
      for (int k = 0; k < 6; k++) begin
         bus_m.mem_rdata = 8'(8'h10 + k);
         #1;
         chk("cont_gnt", 32'({bus_m.gnt1, bus_m.gnt0}), (k % 2 == 0) ? 1 : 2);
         step();
         chk("cont_addr", 32'(bus_m.mem_addr), (k % 2 == 0) ? 'h1000 : 'h1001);
         chk("cont_mem_r", 32'(bus_m.mem_r), 1);
         step();
         step();
         chk("cont_ack", 32'({bus_m.ack1, bus_m.ack0}), (k % 2 == 0) ? 1 : 2);
         chk("cont_rdata", 32'(bus_m.rdata), 32'(8'h10 + k));
         if (k == 5) begin
            bus_m.req0 = 0; bus_m.req1 = 0;
         end
         step();
      end
      chk("cont_idle_busy", 32'(bus_m.busy), 0);

      // single read, port 0
      bus_m.req0 = 1; bus_m.we0 = 0; bus_m.addr0 = 'h2000; bus_m.mem_rdata = 8'hA5;
      #1;
      chk("rd_gnt0", 32'(bus_m.gnt0), 1);
      chk("rd_busy_idle", 32'(bus_m.busy), 0);
      step();
      chk("rd_mem_r1", 32'(bus_m.mem_r), 1);
      chk("rd_mem_w1", 32'(bus_m.mem_w), 0);
      chk("rd_addr", 32'(bus_m.mem_addr), 'h2000);
      chk("rd_gnt0_off", 32'(bus_m.gnt0), 0);
      step();
      chk("rd_mem_r2", 32'(bus_m.mem_r), 1);
      step();
      chk("rd_ack0", 32'(bus_m.ack0), 1);
      chk("rd_ack1", 32'(bus_m.ack1), 0);
      chk("rd_mem_r_done", 32'(bus_m.mem_r), 0);
      chk("rd_rdata", 32'(bus_m.rdata), 'hA5);
      bus_m.req0 = 0;
      step();
      chk("rd_busy_end", 32'(bus_m.busy), 0);
      chk("rd_ack0_end", 32'(bus_m.ack0), 0);

      // single write, port 1; rdata must not pick up mem_rdata
      bus_m.req1 = 1; bus_m.we1 = 1; bus_m.addr1 = 'h8010; bus_m.wdata1 = 8'h3C;
      bus_m.mem_rdata = 8'h77;
      #1;
      chk("wr_gnt1", 32'(bus_m.gnt1), 1);
      chk("wr_gnt0", 32'(bus_m.gnt0), 0);
      step();
      chk("wr_mem_w1", 32'(bus_m.mem_w), 1);
      chk("wr_mem_r1", 32'(bus_m.mem_r), 0);
      chk("wr_addr", 32'(bus_m.mem_addr), 'h8010);
      chk("wr_wdata", 32'(bus_m.mem_wdata), 'h3C);
      step();
      chk("wr_mem_w2", 32'(bus_m.mem_w), 1);
      chk("wr_mem_r2", 32'(bus_m.mem_r), 0);
      step();
      chk("wr_ack1", 32'(bus_m.ack1), 1);
      chk("wr_mem_w_done", 32'(bus_m.mem_w), 0);
      chk("wr_rdata_kept", 32'(bus_m.rdata), 'hA5);
      bus_m.req1 = 0; bus_m.we1 = 0;
      step();
      chk("wr_ack1_end", 32'(bus_m.ack1), 0);
      chk("wr_busy_end", 32'(bus_m.busy), 0);

      // withdrawal and late address change after gnt0
      bus_m.req0 = 1; bus_m.we0 = 1; bus_m.addr0 = 'h4242; bus_m.wdata0 = 8'h11;
      #1;
      chk("wd_gnt0", 32'(bus_m.gnt0), 1);
      step();
      bus_m.req0 = 0; bus_m.addr0 = 'hFFFF; bus_m.wdata0 = 8'h99; bus_m.we0 = 0;
      #1;
      chk("wd_addr1", 32'(bus_m.mem_addr), 'h4242);
      chk("wd_wdata1", 32'(bus_m.mem_wdata), 'h11);
      chk("wd_mem_w1", 32'(bus_m.mem_w), 1);
      step();
      chk("wd_addr2", 32'(bus_m.mem_addr), 'h4242);
      chk("wd_mem_w2", 32'(bus_m.mem_w), 1);
      step();
      chk("wd_ack0", 32'(bus_m.ack0), 1);
      step();
      chk("wd_ack0_once", 32'(bus_m.ack0), 0);
      chk("wd_gnt0_none", 32'(bus_m.gnt0), 0);
      chk("wd_busy_end", 32'(bus_m.busy), 0);
      step();
      chk("wd_ack0_later", 32'(bus_m.ack0), 0);

      // async reset in the second ACCESS cycle; last_winner is 0 beforehand
      bus_m.req0 = 1; bus_m.we0 = 0; bus_m.addr0 = 'h0055;
      #1;
      chk("ra_gnt0", 32'(bus_m.gnt0), 1);
      step();
      step();
      chk("ra_mem_r_pre", 32'(bus_m.mem_r), 1);
      chk("ra_busy_pre", 32'(bus_m.busy), 1);
      #1;
      reset = 1'b0;
      #1;
      chk("ra_mem_r", 32'(bus_m.mem_r), 0);
      chk("ra_mem_w", 32'(bus_m.mem_w), 0);
      chk("ra_busy", 32'(bus_m.busy), 0);
      chk("ra_gnt0", 32'(bus_m.gnt0), 0);
      chk("ra_ack0", 32'(bus_m.ack0), 0);
      bus_m.req0 = 0;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b1;
      step();
      chk("ra_no_ack_a", 32'(bus_m.ack0), 0);
      chk("ra_idle_busy", 32'(bus_m.busy), 0);
      step();
      chk("ra_no_ack_b", 32'(bus_m.ack0), 0);
      bus_m.req0 = 1; bus_m.req1 = 1; bus_m.we1 = 0; bus_m.addr1 = 'h0066;
      #1;
      chk("ra_tie_gnt0", 32'(bus_m.gnt0), 1);
      chk("ra_tie_gnt1", 32'(bus_m.gnt1), 0);
      step();
      step();
      step();
      chk("ra_tie_ack0", 32'(bus_m.ack0), 1);
      bus_m.req0 = 0; bus_m.req1 = 0;
      step();
      chk("ra_end_busy", 32'(bus_m.busy), 0);

      // WAIT_STATES=0: 1-cycle strobe, gnt to ack 2 cycles
      bus_a.req0 = 1; bus_a.addr0 = 'h0300; bus_a.mem_rdata = 8'h5A;
      #1;
      chk("ws0_gnt0", 32'(bus_a.gnt0), 1);
      step();
      chk("ws0_mem_r", 32'(bus_a.mem_r), 1);
      chk("ws0_addr", 32'(bus_a.mem_addr), 'h0300);
      step();
      chk("ws0_ack0", 32'(bus_a.ack0), 1);
      chk("ws0_mem_r_off", 32'(bus_a.mem_r), 0);
      chk("ws0_rdata", 32'(bus_a.rdata), 'h5A);
      bus_a.req0 = 0;
      step();
      chk("ws0_busy_end", 32'(bus_a.busy), 0);

      // WAIT_STATES=3: 4-cycle strobe, gnt to ack 5 cycles
      bus_b.req1 = 1; bus_b.we1 = 0; bus_b.addr1 = 'h0400; bus_b.mem_rdata = 8'hC3;
      #1;
      chk("ws3_gnt1", 32'(bus_b.gnt1), 1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("ws3_mem_r", 32'(bus_b.mem_r), 1);
         chk("ws3_no_ack", 32'(bus_b.ack1), 0);
      end
      step();
      chk("ws3_ack1", 32'(bus_b.ack1), 1);
      chk("ws3_mem_r_off", 32'(bus_b.mem_r), 0);
      chk("ws3_rdata", 32'(bus_b.rdata), 'hC3);
      bus_b.req1 = 0;
      step();
      chk("ws3_busy_end", 32'(bus_b.busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // exclusivity holds on every sampled cycle of the main instance
   always @(negedge clk) begin
      if (reset) begin
         n_chk++;
         assert (!(bus_m.gnt0 && bus_m.gnt1) && !(bus_m.ack0 && bus_m.ack1)
                 && !(bus_m.mem_r && bus_m.mem_w)) n_pass++;
         else begin
            n_fail++;
            $error("FAIL excl: observed gnt=%b%b ack=%b%b r/w=%b%b expected no pair high",
                   bus_m.gnt1, bus_m.gnt0, bus_m.ack1, bus_m.ack0, bus_m.mem_r, bus_m.mem_w);
         end
      end
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 8-bit-data / 16-bit-address memory bus between two requesters: port 0 (CPU core) and port 1 (DMA/video fetch).
- Round-robin arbitration.
- One transaction (one byte read or write) per grant.
- Memory strobes are held for a programmable number of wait states.
- Sits between the CPU/DMA and the RAM/ROM/IO decode; the memory side uses split read and write data with no tristate.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- WAIT_STATES, 1, extra cycles mem_r/mem_w are held beyond the first (0..15).

Ports:
- clk  in  1  system clock, rising edge only.
- reset  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 request; held high until ack0.
- we0  in  1  port 0 write enable (1 = write, 0 = read).
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  one-cycle pulse when port 0 wins arbitration.
- ack0  out  1  one-cycle pulse when port 0's access completes.
- req1, we1, addr1, wdata1, gnt1, ack1: same meaning for port 1.
- rdata  out  DATA_W  read data; valid in the cycle ack0 or ack1 is high.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_r  out  1  read strobe.
- mem_w  out  1  write strobe.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE; all outputs 0; rdata=0.
  - last_winner=1, so port 0 wins the first tie.
  - A transaction in flight is dropped: no ack is issued and the strobes drop immediately.
- FSM has three states: IDLE, ACCESS, DONE.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, that port wins.
  - If both are high, the port != last_winner wins.
  - On a win: latch the winner's addr/we/wdata into mem_addr/mem_wdata and an internal we register; pulse gnt for that cycle; set wait counter=WAIT_STATES; go to ACCESS.
- ACCESS:
  - mem_r = ~we_latched and mem_w = we_latched, asserted for exactly WAIT_STATES+1 cycles.
  - mem_addr and mem_wdata are stable throughout.
  - The counter decrements each cycle.
  - In the cycle the counter is 0: capture mem_rdata into rdata (reads only; writes leave rdata unchanged) and go to DONE.
- DONE:
  - Strobes low; ack for the winner is high for one cycle.
  - last_winner updated to the winner; go to IDLE.
- Latency:
  - Request seen in IDLE to ack is WAIT_STATES+2 cycles.
  - With both ports requesting continuously, the minimum gap between transactions is one IDLE cycle, so grants strictly alternate 0,1,0,1.
- Request rules:
  - A req that drops after gnt does not abort the transaction; ack is still issued.
  - The requester may re-raise req the cycle after ack; it is then evaluated at the next IDLE.
  - The loser's req/addr are ignored until the next IDLE.
  - addr/we/wdata changes after gnt have no effect (they are latched).
- Output exclusivity:
  - gnt0/gnt1 never high together; ack0/ack1 never high together.
  - mem_r and mem_w never high together.
- Wait counter: 4 bits, no wrap; WAIT_STATES > 15 is a parameter error (elaboration assertion).
- A request from either port in the DONE cycle is not seen until IDLE; there is no bypass.

Decomposition:
- Shared package mem_bus_pkg:
  - state enum {IDLE, ACCESS, DONE} (2 bits).
  - Constants PORT_CPU=0, PORT_DMA=1.
  - Default ADDR_W/DATA_W.
- One natural sub-module, rr_arb2: a combinational 2-way round-robin picker. Inputs req[1:0] and last; outputs onehot grant.
- Top holds the FSM, latches, and wait counter.

Test Plan:
- Single read:
  - Stimulus: WAIT_STATES=1; req0=1, we0=0, addr0=0x2000; mem_rdata=0xA5.
  - Required: gnt0 at cycle 1; mem_r high cycles 2-3 with mem_addr=0x2000; ack0 at cycle 4 with rdata=0xA5; busy low at cycle 5.
- Single write:
  - Stimulus: req1=1, we1=1, addr1=0x8010, wdata1=0x3C.
  - Required: mem_w high 2 cycles, mem_addr=0x8010, mem_wdata=0x3C; mem_r never high; ack1 pulses once; rdata unchanged.
- Contention:
  - Stimulus: req0 and req1 both held high for 6 transactions.
  - Required: grant order 0,1,0,1,0,1 immediately after reset; one IDLE cycle between each DONE and the next gnt.
- Wait-state sweep:
  - Stimulus: WAIT_STATES=0 and WAIT_STATES=3.
  - Required: strobe widths of 1 and 4 cycles; req-to-ack latency of 2 and 5 cycles.
- Reset mid-access:
  - Stimulus: reset=0 asynchronously during the second ACCESS cycle.
  - Required: mem_r, mem_w, busy, gnt and ack drop within the same cycle with no clock edge; no ack after release; the next tie goes to port 0.
- Request withdrawal and late address change:
  - Stimulus: req0 drops the cycle after gnt0; addr0 changes to 0xFFFF.
  - Required: access completes at the original address; ack0 issued exactly once.
